sys_ctrl_rx: RTL and testbench

Command decoder and response sequencer downstream of the UART receiver. Consumes the byte stream delivered by the RX path (one `rx_d_vld` pulse per received byte), parses it into register-file write/read and ALU commands, and drives the register file and ALU. Collects each command's result and pushes it, byte by byte, into the TX FIFO.

---
 rtl/sys_ctrl_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_sys_ctrl_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_rx.sv
// sys_ctrl_rx: command decoder and response sequencer behind the UART receiver.
// Parses RX bytes into register-file write/read and ALU commands, then streams
// the command result into the TX FIFO one byte per push.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for an opcode byte (AA/BB/CC/DD), others discarded
// S_WR_ADDR  | write frame: next byte is the register address
// S_WR_DATA  | write frame: next byte is the write data, pulse wr_en
// S_RD_ADDR  | read frame: next byte is the register address, pulse rd_en
// S_RD_WAIT  | waiting for rd_data_vld (bounded by TIMEOUT)
// S_ALU_A    | next byte is operand A, written to register 0
// S_ALU_B    | next byte is operand B, written to register 1
// S_ALU_FUN  | next byte carries the ALU function code, pulse alu_en
// S_ALU_WAIT | waiting for alu_out_vld (bounded by TIMEOUT)
// S_PUSH_LO  | low result byte held back by fifo_full
// S_PUSH_HI  | high result byte of an ALU result pending
module sys_ctrl_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_p_data,
  input  logic                    rx_d_vld,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_data_vld,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_vld,
  input  logic                    fifo_full,
  output logic                    wr_en,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    alu_en,
  output logic [3:0]              alu_fun,
  output logic                    clk_gate_en,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_wr_en
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_PUSH_LO,
    S_PUSH_HI
  } state_t;

  localparam logic [DATA_WIDTH-1:0] OP_WR    = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_A = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_F = DATA_WIDTH'(8'hDD);

  // Wait counter spans 0..TIMEOUT-1; the last value is the final wait cycle.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic [2*DATA_WIDTH-1:0] r_result;
  logic                    r_two_bytes;

  // Command FSM with registered strobes, address/data, clock gate and TX push.
  // When a result arrives with the FIFO not full, the low byte is pushed in
  // the very next cycle, bypassing S_PUSH_LO; fifo_full is looked at one cycle
  // ahead of the push it governs because tx_wr_en is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_result    <= '0;
      r_two_bytes <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      addr        <= '0;
      wr_data     <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      tx_data     <= '0;
      tx_wr_en    <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      alu_en   <= 1'b0;
      tx_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_d_vld) begin
            case (rx_p_data)
              OP_WR:    r_state <= S_WR_ADDR;
              OP_RD:    r_state <= S_RD_ADDR;
              OP_ALU_A: begin
                r_state     <= S_ALU_A;
                clk_gate_en <= 1'b1;
              end
              OP_ALU_F: begin
                r_state     <= S_ALU_FUN;
                clk_gate_en <= 1'b1;
              end
              default:  r_state <= S_IDLE;
            endcase
          end
        end
        S_WR_ADDR: begin
          if (rx_d_vld) begin
            addr    <= rx_p_data[ADDR_WIDTH-1:0];
            r_state <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (rx_d_vld) begin
            wr_data <= rx_p_data;
            wr_en   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (rx_d_vld) begin
            addr       <= rx_p_data[ADDR_WIDTH-1:0];
            rd_en      <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (rd_data_vld) begin
            r_result    <= {{DATA_WIDTH{1'b0}}, rd_data};
            r_two_bytes <= 1'b0;
            r_wait_cnt  <= '0;
            if (!fifo_full) begin
              tx_wr_en <= 1'b1;
              tx_data  <= rd_data;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_PUSH_LO;
            end
          end else if (r_wait_cnt == CNT_LAST) begin
            r_wait_cnt <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_ALU_A: begin
          if (rx_d_vld) begin
            addr    <= '0;
            wr_data <= rx_p_data;
            wr_en   <= 1'b1;
            r_state <= S_ALU_B;
          end
        end
        S_ALU_B: begin
          if (rx_d_vld) begin
            addr    <= ADDR_WIDTH'(1);
            wr_data <= rx_p_data;
            wr_en   <= 1'b1;
            r_state <= S_ALU_FUN;
          end
        end
        S_ALU_FUN: begin
          if (rx_d_vld) begin
            alu_fun    <= rx_p_data[3:0];
            alu_en     <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_ALU_WAIT;
          end
        end
        S_ALU_WAIT: begin
          if (alu_out_vld) begin
            r_result    <= alu_out;
            r_two_bytes <= 1'b1;
            r_wait_cnt  <= '0;
            clk_gate_en <= 1'b0;
            if (!fifo_full) begin
              tx_wr_en <= 1'b1;
              tx_data  <= alu_out[DATA_WIDTH-1:0];
              r_state  <= S_PUSH_HI;
            end else begin
              r_state <= S_PUSH_LO;
            end
          end else if (r_wait_cnt == CNT_LAST) begin
            r_wait_cnt  <= '0;
            clk_gate_en <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_PUSH_LO: begin
          if (!fifo_full) begin
            tx_wr_en <= 1'b1;
            tx_data  <= r_result[DATA_WIDTH-1:0];
            r_state  <= r_two_bytes ? S_PUSH_HI : S_IDLE;
          end
        end
        S_PUSH_HI: begin
          if (!fifo_full) begin
            tx_wr_en <= 1'b1;
            tx_data  <= r_result[2*DATA_WIDTH-1:DATA_WIDTH];
            r_state  <= S_IDLE;
          end
        end
        default: begin
          clk_gate_en <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// tb_sys_ctrl_rx: cycle-accurate vector table for the command frames, plus
// hand-written sequences for the wait timeouts.
module tb_sys_ctrl_rx;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_p_data;
  logic        rx_d_vld;
  logic [7:0]  rd_data;
  logic        rd_data_vld;
  logic [15:0] alu_out;
  logic        alu_out_vld;
  logic        fifo_full;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  addr;
  logic [7:0]  wr_data;
  logic        alu_en;
  logic [3:0]  alu_fun;
  logic        clk_gate_en;
  logic [7:0]  tx_data;
  logic        tx_wr_en;

  sys_ctrl_rx #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_p_data  (rx_p_data),
    .rx_d_vld   (rx_d_vld),
    .rd_data    (rd_data),
    .rd_data_vld(rd_data_vld),
    .alu_out    (alu_out),
    .alu_out_vld(alu_out_vld),
    .fifo_full  (fifo_full),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .alu_en     (alu_en),
    .alu_fun    (alu_fun),
    .clk_gate_en(clk_gate_en),
    .tx_data    (tx_data),
    .tx_wr_en   (tx_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic        rxv;
    logic [7:0]  rxd;
    logic        rdv;
    logic [7:0]  rdd;
    logic        av;
    logic [15:0] ao;
    logic        ff;
    logic [28:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;

  // Count every TX push just after the edge that launches it.
  always @(posedge clk) begin
    #1;
    if (tx_wr_en) n_push++;
  end

  function automatic logic [28:0] outs();
    return {wr_en, rd_en, alu_en, clk_gate_en, tx_wr_en, addr, wr_data, alu_fun, tx_data};
  endfunction

  task automatic add(input logic rs, input logic rxv, input logic [7:0] rxd,
                     input logic rdv, input logic [7:0] rdd,
                     input logic av, input logic [15:0] ao, input logic ff,
                     input logic we, input logic re, input logic ae, input logic cg,
                     input logic tw, input logic [3:0] ad, input logic [7:0] wd,
                     input logic [3:0] af, input logic [7:0] td);
    vec_t v;
    v.rs = rs; v.rxv = rxv; v.rxd = rxd; v.rdv = rdv; v.rdd = rdd;
    v.av = av; v.ao = ao; v.ff = ff;
    v.exp = {we, re, ae, cg, tw, ad, wd, af, td};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge and return at the next one.
  task automatic cyc(input logic rxv, input logic [7:0] rxd, input logic rdv,
                     input logic [7:0] rdd, input logic av, input logic [15:0] ao);
    rx_d_vld = rxv; rx_p_data = rxd; rd_data_vld = rdv; rd_data = rdd;
    alu_out_vld = av; alu_out = ao; fifo_full = 1'b0;
    @(negedge clk);
  endtask

  task automatic byte_in(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 8'h00, 1'b0, 16'h0000);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000);
  endtask

  initial begin
    int base;
    rst = 1'b0; rx_d_vld = 1'b0; rx_p_data = '0; rd_data_vld = 1'b0; rd_data = '0;
    alu_out_vld = 1'b0; alu_out = '0; fifo_full = 1'b0;

    // rs rxv rxd   rdv rdd   av ao       ff | we re ae cg tw ad wd    af td
    // register write AA,05,3C
    add(1,1,8'hAA,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h0,8'h00,4'h0,8'h00);
    add(1,1,8'h05,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h5,8'h00,4'h0,8'h00);
    add(1,1,8'h3C,0,8'h00,0,16'h0000,0, 1,0,0,0,0, 4'h5,8'h3C,4'h0,8'h00);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h5,8'h3C,4'h0,8'h00);
    // register read BB,07, result 5A held off by three full cycles
    add(1,1,8'hBB,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h5,8'h3C,4'h0,8'h00);
    add(1,1,8'h07,0,8'h00,0,16'h0000,0, 0,1,0,0,0, 4'h7,8'h3C,4'h0,8'h00);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h7,8'h3C,4'h0,8'h00);
    add(1,0,8'h00,1,8'h5A,0,16'h0000,1, 0,0,0,0,0, 4'h7,8'h3C,4'h0,8'h00);
    add(1,0,8'h00,0,8'h00,0,16'h0000,1, 0,0,0,0,0, 4'h7,8'h3C,4'h0,8'h00);
    add(1,0,8'h00,0,8'h00,0,16'h0000,1, 0,0,0,0,0, 4'h7,8'h3C,4'h0,8'h00);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,1, 4'h7,8'h3C,4'h0,8'h5A);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h7,8'h3C,4'h0,8'h5A);
    // ALU with operands CC,12,34,01 -> 0x0046
    add(1,1,8'hCC,0,8'h00,0,16'h0000,0, 0,0,0,1,0, 4'h7,8'h3C,4'h0,8'h5A);
    add(1,1,8'h12,0,8'h00,0,16'h0000,0, 1,0,0,1,0, 4'h0,8'h12,4'h0,8'h5A);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,1,0, 4'h0,8'h12,4'h0,8'h5A);
    add(1,1,8'h34,0,8'h00,0,16'h0000,0, 1,0,0,1,0, 4'h1,8'h34,4'h0,8'h5A);
    add(1,1,8'h01,0,8'h00,0,16'h0000,0, 0,0,1,1,0, 4'h1,8'h34,4'h1,8'h5A);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,1,0, 4'h1,8'h34,4'h1,8'h5A);
    add(1,0,8'h00,0,8'h00,1,16'h0046,0, 0,0,0,0,1, 4'h1,8'h34,4'h1,8'h46);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,1, 4'h1,8'h34,4'h1,8'h00);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h1,8'h34,4'h1,8'h00);
    // ALU only DD,02 -> 0xABCD, then DD,03 aborted by reset in ALU_WAIT
    add(1,1,8'hDD,0,8'h00,0,16'h0000,0, 0,0,0,1,0, 4'h1,8'h34,4'h1,8'h00);
    add(1,1,8'h02,0,8'h00,0,16'h0000,0, 0,0,1,1,0, 4'h1,8'h34,4'h2,8'h00);
    add(1,0,8'h00,0,8'h00,1,16'hABCD,0, 0,0,0,0,1, 4'h1,8'h34,4'h2,8'hCD);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,1, 4'h1,8'h34,4'h2,8'hAB);
    add(1,1,8'hDD,0,8'h00,0,16'h0000,0, 0,0,0,1,0, 4'h1,8'h34,4'h2,8'hAB);
    add(1,1,8'h03,0,8'h00,0,16'h0000,0, 0,0,1,1,0, 4'h1,8'h34,4'h3,8'hAB);
    add(1,0,8'h00,1,8'h11,0,16'h0000,0, 0,0,0,1,0, 4'h1,8'h34,4'h3,8'hAB);
    add(0,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h0,8'h00,4'h0,8'h00);
    add(0,0,8'h00,0,8'h00,1,16'h1234,0, 0,0,0,0,0, 4'h0,8'h00,4'h0,8'h00);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h0,8'h00,4'h0,8'h00);
    add(1,0,8'h00,0,8'h00,1,16'h1234,0, 0,0,0,0,0, 4'h0,8'h00,4'h0,8'h00);
    // invalid opcode 55, read of address 2 with bytes dropped while waiting
    add(1,1,8'h55,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h0,8'h00,4'h0,8'h00);
    add(1,1,8'hBB,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h0,8'h00,4'h0,8'h00);
    add(1,1,8'h02,0,8'h00,0,16'h0000,0, 0,1,0,0,0, 4'h2,8'h00,4'h0,8'h00);
    add(1,1,8'hAA,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h2,8'h00,4'h0,8'h00);
    add(1,1,8'h3C,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h2,8'h00,4'h0,8'h00);
    add(1,0,8'h00,0,8'h00,1,16'h9999,0, 0,0,0,0,0, 4'h2,8'h00,4'h0,8'h00);
    add(1,0,8'h00,1,8'h77,0,16'h0000,0, 0,0,0,0,1, 4'h2,8'h00,4'h0,8'h77);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h2,8'h00,4'h0,8'h77);
    add(1,1,8'h05,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h2,8'h00,4'h0,8'h77);
    // ALU DD,0F -> 0xBEEF with the high byte held off by two full cycles
    add(1,1,8'hDD,0,8'h00,0,16'h0000,0, 0,0,0,1,0, 4'h2,8'h00,4'h0,8'h77);
    add(1,1,8'h0F,0,8'h00,0,16'h0000,0, 0,0,1,1,0, 4'h2,8'h00,4'hF,8'h77);
    add(1,0,8'h00,0,8'h00,1,16'hBEEF,0, 0,0,0,0,1, 4'h2,8'h00,4'hF,8'hEF);
    add(1,0,8'h00,0,8'h00,0,16'h0000,1, 0,0,0,0,0, 4'h2,8'h00,4'hF,8'hEF);
    add(1,0,8'h00,0,8'h00,0,16'h0000,1, 0,0,0,0,0, 4'h2,8'h00,4'hF,8'hEF);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,1, 4'h2,8'h00,4'hF,8'hBE);
    add(1,0,8'h00,0,8'h00,0,16'h0000,0, 0,0,0,0,0, 4'h2,8'h00,4'hF,8'hBE);

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(outs()), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rs; rx_d_vld = vecs[i].rxv; rx_p_data = vecs[i].rxd;
      rd_data_vld = vecs[i].rdv; rd_data = vecs[i].rdd;
      alu_out_vld = vecs[i].av; alu_out = vecs[i].ao; fifo_full = vecs[i].ff;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    rst = 1'b1;
    idle(2);

    // read timeout: no push, late valid ignored, then a write frame works
    base = n_push;
    byte_in(8'hBB);
    byte_in(8'h01);
    check("to_rd_strobe", {27'h0, rd_en, addr}, {27'h0, 1'b1, 4'h1});
    idle(TIMEOUT + 5);
    check("to_rd_no_push", n_push - base, 0);
    cyc(1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 16'h0000);
    idle(3);
    check("to_rd_late_vld", n_push - base, 0);
    byte_in(8'hAA);
    byte_in(8'h01);
    byte_in(8'hFF);
    check("to_after_write", {19'h0, wr_en, addr, wr_data}, {19'h0, 1'b1, 4'h1, 8'hFF});

    // counter restarts on entry: a valid well inside the window is accepted
    byte_in(8'hBB);
    byte_in(8'h03);
    idle(200);
    cyc(1'b0, 8'h00, 1'b1, 8'h42, 1'b0, 16'h0000);
    check("rd_late_ok", {23'h0, tx_wr_en, tx_data}, {23'h0, 1'b1, 8'h42});
    idle(2);

    // ALU timeout: clock gate drops, nothing pushed, late result ignored
    base = n_push;
    byte_in(8'hDD);
    byte_in(8'h04);
    check("to_alu_strobe", {26'h0, alu_en, alu_fun, clk_gate_en}, {26'h0, 1'b1, 4'h4, 1'b1});
    idle(TIMEOUT + 5);
    check("to_alu_gate_off", {31'h0, clk_gate_en}, 32'h0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 16'h1111);
    idle(3);
    check("to_alu_no_push", n_push - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
